// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared sizing for the multi-lane register rename block: default array
// sizes and lane counts, plus small constant helpers that derive index and
// pointer widths and locate a lane's slice inside a lane-packed bus.
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int ARCHFILE_SIZE_DEF = 32;
   localparam int PHYSFILE_SIZE_DEF = 256;
   localparam int REG_SIZE_DEF      = 32;
   localparam int ISSUE_WIDTH_DEF   = 2;
   localparam int RING_PORTS_DEF    = 2;
   localparam int COMMIT_WIDTH_DEF  = 2;

   // Index width for a table of n entries (n a power of two).
   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   // Circular-buffer pointer width: one extra wrap bit so full and empty differ.
   function automatic int ptr_w(input int n);
      return $clog2(n) + 1;
   endfunction

   // Width of a counter that must hold 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // LSB position of lane 'lane' in a lane-packed bus of 'width'-bit fields.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/regfile_freelist.sv
// ---------------------------------------------------------------------------
// regfile_freelist
// Circular free list of physical register numbers.
//   - pop:     the top may take up to ISSUE_WIDTH entries per cycle; the
//              entries at head, head+1, ... are always presented on pop_data
//              and head advances by pop_cnt.
//   - push:    each set push_valid lane appends its push_data at the tail,
//              compacted in lane order.
//   - retire:  every push also advances the retire-head checkpoint by one,
//              since each retired mapping releases exactly one old register.
//   - restore: head is reloaded from the retire-head (including this
//              cycle's pushes).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pop_cnt       number of entries consumed this cycle
//   pop_data      ISSUE_WIDTH entries starting at head, lane 0 in LSBs
//   push_valid    per-commit-lane push strobe
//   push_data     per-commit-lane register number to return
//   restore       rollback: head := retire-head
//   free_cnt      tail - head
// ---------------------------------------------------------------------------
module regfile_freelist
   import regfile_pkg::*;
#(
   parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF,
   parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
   parameter int ISSUE_WIDTH   = ISSUE_WIDTH_DEF,
   parameter int COMMIT_WIDTH  = COMMIT_WIDTH_DEF,
   localparam int P  = idx_w(PHYSFILE_SIZE),
   localparam int PT = ptr_w(PHYSFILE_SIZE),
   localparam int CW = cnt_w(ISSUE_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CW-1:0]             pop_cnt,
   output logic [ISSUE_WIDTH*P-1:0]  pop_data,
   input  logic [COMMIT_WIDTH-1:0]   push_valid,
   input  logic [COMMIT_WIDTH*P-1:0] push_data,
   input  logic                      restore,
   output logic [PT-1:0]             free_cnt
);

   localparam int PW = cnt_w(COMMIT_WIDTH);

   logic [P-1:0]  mem [PHYSFILE_SIZE];
   logic [PT-1:0] head;
   logic [PT-1:0] tail;
   logic [PT-1:0] ret_head;
   logic [PT-1:0] ret_head_nxt;
   logic [PW-1:0] push_cnt;
   logic [P-1:0]  push_idx [COMMIT_WIDTH];

   // Compact valid pushes onto consecutive tail slots in lane order.
   always_comb begin
      push_cnt = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         push_idx[k] = tail[P-1:0] + P'(push_cnt);
         if (push_valid[k]) begin
            push_cnt = push_cnt + PW'(1);
         end
      end
   end

   always_comb begin
      pop_data = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         pop_data[lane_lsb(k, P) +: P] = mem[head[P-1:0] + P'(k)];
      end
   end

   assign ret_head_nxt = ret_head + PT'(push_cnt);
   assign free_cnt     = tail - head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Registers below ARCHFILE_SIZE are the initial architectural
         // mappings; everything above starts free, in ascending order.
         for (int e = 0; e < PHYSFILE_SIZE; e++) begin
            mem[e] <= (e < PHYSFILE_SIZE - ARCHFILE_SIZE) ? P'(e + ARCHFILE_SIZE) : '0;
         end
         head     <= '0;
         ret_head <= '0;
         tail     <= PT'(PHYSFILE_SIZE - ARCHFILE_SIZE);
      end else begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (push_valid[k]) begin
               mem[push_idx[k]] <= push_data[lane_lsb(k, P) +: P];
            end
         end
         tail     <= tail + PT'(push_cnt);
         ret_head <= ret_head_nxt;
         head     <= restore ? ret_head_nxt : head + PT'(pop_cnt);
      end
   end

endmodule

// File: rtl/regfile_rename_multi.sv
// ---------------------------------------------------------------------------
// regfile_rename_multi
// Multi-lane register renamer with physical register file.
// Holds a speculative RAT (updated by rename), a retirement RAT (updated by
// commit), per-physical-register ready bits and values, and a free list.
// Rename results are combinational in the request cycle; all state moves on
// posedge clk.
// Ports (lane-packed, lane 0 in LSBs):
//   clk, rst                      clock, asynchronous active-high reset
//   uop_valid, arch_rd1/2, arch_wr rename requests
//   ring_valid/phys/val           writeback ports
//   rob_valid/arch/phys/free      commit lanes
//   rollback                      discard speculative state
//   phys_rd1/2, *_rdy, *_val      renamed sources with readiness and data
//   phys_wr                       allocated destination per lane
//   none_free                     fewer than ISSUE_WIDTH free registers
// ---------------------------------------------------------------------------
module regfile_rename_multi
   import regfile_pkg::*;
#(
   parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
   parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF,
   parameter int REG_SIZE      = REG_SIZE_DEF,
   parameter int ISSUE_WIDTH   = ISSUE_WIDTH_DEF,
   parameter int RING_PORTS    = RING_PORTS_DEF,
   parameter int COMMIT_WIDTH  = COMMIT_WIDTH_DEF,
   localparam int A = idx_w(ARCHFILE_SIZE),
   localparam int P = idx_w(PHYSFILE_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ISSUE_WIDTH-1:0]           uop_valid,
   input  logic [ISSUE_WIDTH*A-1:0]         arch_rd1,
   input  logic [ISSUE_WIDTH*A-1:0]         arch_rd2,
   input  logic [ISSUE_WIDTH*A-1:0]         arch_wr,
   input  logic [RING_PORTS-1:0]            ring_valid,
   input  logic [RING_PORTS*P-1:0]          ring_phys,
   input  logic [RING_PORTS*REG_SIZE-1:0]   ring_val,
   input  logic [COMMIT_WIDTH-1:0]          rob_valid,
   input  logic [COMMIT_WIDTH*A-1:0]        rob_arch,
   input  logic [COMMIT_WIDTH*P-1:0]        rob_phys,
   input  logic [COMMIT_WIDTH*P-1:0]        rob_free,
   input  logic                             rollback,
   output logic [ISSUE_WIDTH*P-1:0]         phys_rd1,
   output logic [ISSUE_WIDTH*P-1:0]         phys_rd2,
   output logic [ISSUE_WIDTH-1:0]           phys_rd1_rdy,
   output logic [ISSUE_WIDTH-1:0]           phys_rd2_rdy,
   output logic [ISSUE_WIDTH*REG_SIZE-1:0]  phys_rd1_val,
   output logic [ISSUE_WIDTH*REG_SIZE-1:0]  phys_rd2_val,
   output logic [ISSUE_WIDTH*P-1:0]         phys_wr,
   output logic                             none_free
);

   localparam int CW = cnt_w(ISSUE_WIDTH);
   localparam int PT = ptr_w(PHYSFILE_SIZE);

   logic [P-1:0]              spec_rat    [ARCHFILE_SIZE];
   logic [P-1:0]              ret_rat     [ARCHFILE_SIZE];
   logic [P-1:0]              ret_rat_nxt [ARCHFILE_SIZE];
   logic [PHYSFILE_SIZE-1:0]  rdy;
   logic [REG_SIZE-1:0]       val [PHYSFILE_SIZE];

   logic [ISSUE_WIDTH-1:0]    alloc;
   logic [CW-1:0]             alloc_cnt;
   logic [CW-1:0]             pop_cnt;
   logic [ISSUE_WIDTH*P-1:0]  pop_data;
   logic [COMMIT_WIDTH-1:0]   commit;
   logic [PT-1:0]             free_cnt;
   logic                      accept;

   regfile_freelist #(
      .PHYSFILE_SIZE (PHYSFILE_SIZE),
      .ARCHFILE_SIZE (ARCHFILE_SIZE),
      .ISSUE_WIDTH   (ISSUE_WIDTH),
      .COMMIT_WIDTH  (COMMIT_WIDTH)
   ) u_freelist (
      .clk        (clk),
      .rst        (rst),
      .pop_cnt    (pop_cnt),
      .pop_data   (pop_data),
      .push_valid (commit),
      .push_data  (rob_free),
      .restore    (rollback),
      .free_cnt   (free_cnt)
   );

   // Writes to arch 0 never allocate: it is hard-wired to phys 0.
   always_comb begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         alloc[i] = uop_valid[i] && (arch_wr[lane_lsb(i, A) +: A] != '0);
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         commit[k] = rob_valid[k] && (rob_arch[lane_lsb(k, A) +: A] != '0);
      end
   end

   // Allocating lanes take consecutive free-list entries in lane order.
   always_comb begin
      alloc_cnt = '0;
      phys_wr   = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         if (alloc[i]) begin
            phys_wr[lane_lsb(i, P) +: P] = pop_data[lane_lsb(int'(alloc_cnt), P) +: P];
            alloc_cnt = alloc_cnt + CW'(1);
         end
      end
   end

   // Stall is conservative: a group is held whenever a full-width group
   // could not be satisfied, regardless of how many lanes actually allocate.
   assign none_free = free_cnt < PT'(ISSUE_WIDTH);
   assign accept    = !none_free && !rollback;
   assign pop_cnt   = accept ? alloc_cnt : '0;

   // Source lookup: RAT, then older-lane destinations in the same group
   // (later lanes override earlier ones), then same-cycle writeback.
   always_comb begin
      logic [A-1:0]        src_a;
      logic [P-1:0]        src_p;
      logic                src_r;
      logic [REG_SIZE-1:0] src_v;
      phys_rd1     = '0;
      phys_rd2     = '0;
      phys_rd1_rdy = '0;
      phys_rd2_rdy = '0;
      phys_rd1_val = '0;
      phys_rd2_val = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         for (int s = 0; s < 2; s++) begin
            src_a = (s == 0) ? arch_rd1[lane_lsb(i, A) +: A] : arch_rd2[lane_lsb(i, A) +: A];
            src_p = spec_rat[src_a];
            src_r = rdy[src_p];
            src_v = val[src_p];
            for (int j = 0; j < i; j++) begin
               if (alloc[j] && (arch_wr[lane_lsb(j, A) +: A] == src_a)) begin
                  src_p = phys_wr[lane_lsb(j, P) +: P];
                  src_r = 1'b0;
                  src_v = '0;
               end
            end
            for (int k = 0; k < RING_PORTS; k++) begin
               if (ring_valid[k] && (ring_phys[lane_lsb(k, P) +: P] == src_p) && (src_p != '0)) begin
                  src_r = 1'b1;
                  src_v = ring_val[lane_lsb(k, REG_SIZE) +: REG_SIZE];
               end
            end
            if (src_a == '0) begin
               src_p = '0;
               src_r = 1'b1;
               src_v = '0;
            end
            if (s == 0) begin
               phys_rd1[lane_lsb(i, P) +: P]               = src_p;
               phys_rd1_rdy[i]                             = src_r;
               phys_rd1_val[lane_lsb(i, REG_SIZE) +: REG_SIZE] = src_v;
            end else begin
               phys_rd2[lane_lsb(i, P) +: P]               = src_p;
               phys_rd2_rdy[i]                             = src_r;
               phys_rd2_val[lane_lsb(i, REG_SIZE) +: REG_SIZE] = src_v;
            end
         end
      end
   end

   // Retirement RAT after this cycle's commits; rollback copies this value so
   // that same-cycle commits are already folded in.
   always_comb begin
      for (int a = 0; a < ARCHFILE_SIZE; a++) begin
         ret_rat_nxt[a] = ret_rat[a];
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (commit[k]) begin
            ret_rat_nxt[rob_arch[lane_lsb(k, A) +: A]] = rob_phys[lane_lsb(k, P) +: P];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < ARCHFILE_SIZE; a++) begin
            spec_rat[a] <= P'(a);
            ret_rat[a]  <= P'(a);
         end
         rdy <= '1;
         for (int p = 0; p < PHYSFILE_SIZE; p++) begin
            val[p] <= '0;
         end
      end else begin
         for (int a = 0; a < ARCHFILE_SIZE; a++) begin
            ret_rat[a] <= ret_rat_nxt[a];
         end
         for (int k = 0; k < RING_PORTS; k++) begin
            if (ring_valid[k] && (ring_phys[lane_lsb(k, P) +: P] != '0)) begin
               val[ring_phys[lane_lsb(k, P) +: P]] <= ring_val[lane_lsb(k, REG_SIZE) +: REG_SIZE];
               rdy[ring_phys[lane_lsb(k, P) +: P]] <= 1'b1;
            end
         end
         if (rollback) begin
            for (int a = 0; a < ARCHFILE_SIZE; a++) begin
               spec_rat[a] <= ret_rat_nxt[a];
            end
            rdy <= '1;
         end else if (accept) begin
            // Ascending lane order: the highest lane's mapping lands last,
            // and a clear placed after the ring write overrides it.
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
               if (alloc[i]) begin
                  spec_rat[arch_wr[lane_lsb(i, A) +: A]] <= phys_wr[lane_lsb(i, P) +: P];
                  rdy[phys_wr[lane_lsb(i, P) +: P]]      <= 1'b0;
               end
            end
         end
      end
   end

endmodule
